// File: rtl/cdf_streamer.sv
// cdf_streamer: walks the histogram bins, accumulates the CDF and hands each value to the divider.
// Build option CDF_SATURATE_EN: accumulator clamps at all-ones instead of wrapping.
module cdf_streamer #(
   parameter int NUM_BINS = 256,
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              start,
   output logic [ADDR_W-1:0] hist_addr,
   output logic              hist_rd_en,
   input  logic [DATA_W-1:0] hist_data,
   output logic [DATA_W-1:0] cdf_out,
   output logic              div_en,
   input  logic              ready_g_out,
   output logic [ADDR_W-1:0] bin_idx,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_CAPTURE,
      S_ISSUE,
      S_WAIT_DIV,
      S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(NUM_BINS - 1);

   state_t            state_q;
   state_t            state_d;
   logic [DATA_W-1:0] acc_q;
   logic [DATA_W-1:0] acc_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every output of this block is given a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      hist_rd_en = 1'b0;
      div_en     = 1'b0;
      done       = 1'b0;
      busy       = (state_q != S_IDLE);
      if (enable) begin
         unique case (state_q)
            S_IDLE: begin
               if (start) state_d = S_READ;
            end
            S_READ: begin
               hist_rd_en = 1'b1;
               state_d    = S_CAPTURE;
            end
            S_CAPTURE: begin
               state_d = S_ISSUE;
            end
            S_ISSUE: begin
               div_en  = 1'b1;
               state_d = S_WAIT_DIV;
            end
            S_WAIT_DIV: begin
               if (ready_g_out) state_d = (bin_idx == LAST_BIN) ? S_DONE : S_READ;
            end
            S_DONE: begin
               done    = 1'b1;
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

`ifdef CDF_SATURATE_EN
   logic [DATA_W:0] sum_wide;
   assign sum_wide = {1'b0, acc_q} + {1'b0, hist_data};
   assign acc_next = sum_wide[DATA_W] ? {DATA_W{1'b1}} : sum_wide[DATA_W-1:0];
`else
   assign acc_next = acc_q + hist_data;
`endif

   // Address and index advance only when the divider result is accepted, so the LUT write lines up.
   // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q     <= '0;
         cdf_out   <= '0;
         hist_addr <= '0;
         bin_idx   <= '0;
      end else if (enable) begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  acc_q     <= '0;
                  hist_addr <= '0;
                  bin_idx   <= '0;
               end
            end
            S_CAPTURE: begin
               acc_q   <= acc_next;
               cdf_out <= acc_next;
            end
            S_WAIT_DIV: begin
               if (ready_g_out && (bin_idx != LAST_BIN)) begin
                  hist_addr <= hist_addr + 1'b1;
                  bin_idx   <= bin_idx + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
